trip_event_reporter: RTL and testbench

- Opposite end of the ADC-processing comparator path: consumes per-channel trip_high/trip_low flags and transmits them as timestamped event beats on an AXI-stream master toward the fault logger/DMA.
- Detects rising and falling edges on every trip bit and queues one pending event per bit.
- Serialises pending events onto the stream in priority order.
- Drives the comparators' clear_latch pulse on request.

---
 rtl/trip_event_reporter_if.sv | 16 +
 rtl/trip_event_reporter.sv | 157 +++++++++++++++
 tb/tb_trip_event_reporter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trip_event_reporter_if.sv
// AXI-stream link carrying trip event beats from the reporter to the fault logger.
interface axi_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;

    modport master (output valid, data, last, dest, user, input ready);
    modport slave  (input valid, data, last, dest, user, output ready);
endinterface

// File: rtl/trip_event_reporter.sv
// Turns comparator trip-flag edges into timestamped AXI-stream event beats.
// Event beat valid one cycle after the edge is sampled; stream stalls hold the beat, extra edges on a pending bit set overflow.
module trip_event_reporter #(
    parameter int N_CHANNELS      = 4,
    parameter int TIMESTAMP_WIDTH = 24,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_CHANNELS-1:0] trip_high,
    input  logic [N_CHANNELS-1:0] trip_low,
    input  logic                  clear_request,
    axi_stream.master             data_out,
    output logic                  clear_latch,
    output logic                  fault,
    output logic                  overflow
);
    localparam int NB = 2 * N_CHANNELS;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state_q, state_d;
    logic [TIMESTAMP_WIDTH-1:0] counter_q, counter_d;
    logic [NB-1:0]              sample_q, sample_d;
    logic [NB-1:0]              pending_q, pending_d;
    logic [TIMESTAMP_WIDTH-1:0] ts_q [NB];
    logic [TIMESTAMP_WIDTH-1:0] ts_d [NB];
    logic [NB-1:0]              dir_q, dir_d;
    logic                       valid_q, valid_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       last_q, last_d;
    logic                       clear_latch_q, clear_latch_d;
    logic                       fault_q, fault_d;
    logic                       overflow_q, overflow_d;

    logic [NB-1:0]              trip_vec, set_vec, sel_vec, consume_vec;
    logic                       sel_found, sel_dir, sel_high, load, lost;
    logic [TIMESTAMP_WIDTH-1:0] sel_ts;
    logic [4:0]                 sel_chan;
    logic [DATA_WIDTH-9:0]      ts_ext;
    logic [DATA_WIDTH-1:0]      beat_dat;

    // Low trips occupy the low half so a plain lowest-bit-first scan gives the required priority.
    assign trip_vec = {trip_high, trip_low};

    always_comb begin
        counter_d     = counter_q + TIMESTAMP_WIDTH'(1);
        sample_d      = trip_vec;
        set_vec       = enable ? (trip_vec ^ sample_q) : '0;
        clear_latch_d = clear_request;
        fault_d       = |trip_vec;

        sel_found = 1'b0;
        sel_vec   = '0;
        sel_ts    = '0;
        sel_dir   = 1'b0;
        sel_high  = 1'b0;
        sel_chan  = '0;
        for (int i = 0; i < NB; i++) begin
            if (!sel_found && pending_q[i]) begin
                sel_found  = 1'b1;
                sel_vec[i] = 1'b1;
                sel_ts     = ts_q[i];
                sel_dir    = dir_q[i];
                sel_high   = (i >= N_CHANNELS);
                sel_chan   = (i >= N_CHANNELS) ? 5'(i - N_CHANNELS) : 5'(i);
            end
        end

        ts_ext                    = '0;
        ts_ext[TIMESTAMP_WIDTH-1:0] = sel_ts;
        beat_dat                  = {ts_ext, sel_dir, sel_high, 1'b0, sel_chan};

        load        = sel_found && ((state_q == IDLE) || data_out.ready);
        consume_vec = load ? sel_vec : '0;

        // A new edge on the bit being consumed is a fresh event; on any other pending bit it is lost.
        pending_d = (pending_q & ~consume_vec) | set_vec;
        lost      = |(set_vec & pending_q & ~consume_vec);
        ts_d      = ts_q;
        dir_d     = dir_q;
        for (int b = 0; b < NB; b++) begin
            if (set_vec[b] && (!pending_q[b] || consume_vec[b])) begin
                ts_d[b]  = counter_q;
                dir_d[b] = trip_vec[b];
            end
        end
        overflow_d = (overflow_q && !clear_request) || lost;

        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = beat_dat;
                    last_d  = ((pending_q & ~sel_vec) == '0);
                end
            end
            SEND: begin
                if (data_out.ready) begin
                    if (load) begin
                        data_d = beat_dat;
                        last_d = ((pending_q & ~sel_vec) == '0);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            sample_q      <= '0;
            pending_q     <= '0;
            dir_q         <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            last_q        <= 1'b0;
            clear_latch_q <= 1'b0;
            fault_q       <= 1'b0;
            overflow_q    <= 1'b0;
            for (int b = 0; b < NB; b++) ts_q[b] <= '0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            sample_q      <= sample_d;
            pending_q     <= pending_d;
            dir_q         <= dir_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            last_q        <= last_d;
            clear_latch_q <= clear_latch_d;
            fault_q       <= fault_d;
            overflow_q    <= overflow_d;
            for (int b = 0; b < NB; b++) ts_q[b] <= ts_d[b];
        end
    end

    assign data_out.valid = valid_q;
    assign data_out.data  = data_q;
    assign data_out.last  = last_q;
    assign data_out.dest  = '0;
    assign data_out.user  = '0;
    assign clear_latch    = clear_latch_q;
    assign fault          = fault_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_trip_event_reporter.sv
// Directed and randomized checks of trip_event_reporter against an event-level reference model.
module tb_trip_event_reporter;
    localparam int N   = 4;
    localparam int NB  = 2 * N;
    localparam int TSW = 8;
    localparam int DW  = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b1;
    logic [N-1:0] trip_high = '0;
    logic [N-1:0] trip_low = '0;
    logic         clear_request = 1'b0;
    logic         clear_latch, fault, overflow;

    axi_stream #(.DATA_WIDTH(DW)) bus ();

    trip_event_reporter #(.N_CHANNELS(N), .TIMESTAMP_WIDTH(TSW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .trip_high(trip_high), .trip_low(trip_low), .clear_request(clear_request),
        .data_out(bus), .clear_latch(clear_latch), .fault(fault), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: pending events per bit, an output beat slot, and the sticky flags.
    bit [NB-1:0] m_prev, m_pend;
    int          m_evts [NB];
    bit          m_edir [NB];
    bit          m_valid, m_last, m_ovf, m_clr, m_fault;
    logic [31:0] m_data;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_prev = '0; m_pend = '0; m_valid = 0; m_last = 0; m_ovf = 0;
        m_clr = 0; m_fault = 0; m_data = '0; m_cnt = 0;
        for (int b = 0; b < NB; b++) begin m_evts[b] = 0; m_edir[b] = 0; end
    endtask

    task automatic model_edge();
        bit [NB-1:0] vec;
        bit lost;
        int pick;
        vec  = {trip_high, trip_low};
        lost = 0;
        if (!m_valid || bus.ready) begin
            pick = -1;
            for (int b = NB - 1; b >= 0; b--) if (m_pend[b]) pick = b;
            if (pick >= 0) begin
                m_pend[pick] = 0;
                m_data  = 32'(m_evts[pick] * 256 + (m_edir[pick] ? 128 : 0)
                              + (pick >= N ? 64 : 0) + pick % N);
                m_last  = (m_pend == 0);
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (enable && vec[b] != m_prev[b]) begin
                if (m_pend[b]) lost = 1;
                else begin
                    m_pend[b] = 1; m_evts[b] = m_cnt; m_edir[b] = vec[b];
                end
            end
        end
        m_ovf   = (m_ovf && !clear_request) || lost;
        m_clr   = clear_request;
        m_fault = |vec;
        m_prev  = vec;
        m_cnt   = (m_cnt + 1) % (1 << TSW);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(bus.valid), 64'(m_valid));
        chk({tag, ".data"}, 64'(bus.data), 64'(m_data));
        chk({tag, ".last"}, 64'(bus.last), 64'(m_last));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".clear_latch"}, 64'(clear_latch), 64'(m_clr));
        chk({tag, ".fault"}, 64'(fault), 64'(m_fault));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int          ts_seen;
    logic [31:0] dat;

    initial begin
        bus.ready = 1'b1;
        model_clear();
        #12;
        chk("rst.valid", 64'(bus.valid), 64'd0);
        chk("rst.data", 64'(bus.data), 64'd0);
        chk("rst.last", 64'(bus.last), 64'd0);
        chk("rst.clear_latch", 64'(clear_latch), 64'd0);
        chk("rst.fault", 64'(fault), 64'd0);
        chk("rst.overflow", 64'(overflow), 64'd0);
        chk("rst.dest", 64'(bus.dest), 64'd0);
        chk("rst.user", 64'(bus.user), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single low-channel rise at counter 100.
        while (m_cnt != 100) step("idle");
        trip_low[2] = 1'b1;
        step("t1.edge");
        chk("t1.fault", 64'(fault), 64'd1);
        chk("t1.novalid", 64'(bus.valid), 64'd0);
        step("t1.beat");
        chk("t1.valid", 64'(bus.valid), 64'd1);
        dat = bus.data;
        chk("t1.byte", 64'(dat[7:0]), 64'h82);
        chk("t1.ts", 64'(dat[31:8]), 64'd100);
        chk("t1.last", 64'(bus.last), 64'd1);
        step("t1.drain");
        chk("t1.drop", 64'(bus.valid), 64'd0);

        // Simultaneous high ch0 and low ch3 rises: low first, back to back.
        trip_high[0] = 1'b1; trip_low[3] = 1'b1;
        step("t2.edge");
        step("t2.b0");
        dat = bus.data;
        ts_seen = int'(dat[31:8]);
        chk("t2.b0.byte", 64'(dat[7:0]), 64'h83);
        chk("t2.b0.last", 64'(bus.last), 64'd0);
        step("t2.b1");
        dat = bus.data;
        chk("t2.b1.valid", 64'(bus.valid), 64'd1);
        chk("t2.b1.byte", 64'(dat[7:0]), 64'hC0);
        chk("t2.b1.ts", 64'(dat[31:8]), 64'(ts_seen));
        chk("t2.b1.last", 64'(bus.last), 64'd1);
        step("t2.drain");

        // Stalled stream while trip_low[1] rises, falls and rises.
        bus.ready = 1'b0;
        trip_low[1] = 1'b1;
        step("t3.rise");
        step("t3.load");
        dat = bus.data;
        chk("t3.first", 64'(dat[7:0]), 64'h81);
        trip_low[1] = 1'b0;
        step("t3.fall");
        trip_low[1] = 1'b1;
        step("t3.rise2");
        for (int i = 0; i < 6; i++) step("t3.stall");
        chk("t3.held", 64'(bus.data[7:0]), 64'h81);
        chk("t3.ovf", 64'(overflow), 64'd1);
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) step("t3.drain");
        chk("t3.ovf_sticky", 64'(overflow), 64'd1);
        clear_request = 1'b1;
        step("t3.clr");
        clear_request = 1'b0;
        chk("t3.clr_pulse", 64'(clear_latch), 64'd1);
        chk("t3.ovf_clear", 64'(overflow), 64'd0);
        step("t3.after");
        chk("t3.clr_done", 64'(clear_latch), 64'd0);

        // Drop all trips, drain, then toggle with capture disabled.
        trip_high = '0; trip_low = '0;
        for (int i = 0; i < 12; i++) step("t4.drain");
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            trip_high[1] = ~trip_high[1];
            step("t4.toggle");
            chk("t4.fault", 64'(fault), 64'(trip_high[1]));
            chk("t4.novalid", 64'(bus.valid), 64'd0);
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step("t4.enabled");
        chk("t4.quiet", 64'(bus.valid), 64'd0);

        // Timestamp wrap: edges at counter all-ones and at 1.
        while (m_cnt != 255) step("t5.wait");
        trip_high[2] = ~trip_high[2];
        step("t5.edge_ff");
        step("t5.beat_ff");
        chk("t5.ts_ff", 64'(bus.data[31:8]), 64'hFF);
        while (m_cnt != 1) step("t5.wait1");
        trip_high[2] = ~trip_high[2];
        step("t5.edge_01");
        step("t5.beat_01");
        chk("t5.ts_01", 64'(bus.data[31:8]), 64'h01);

        // Randomized traffic with stalls, capture gating and clears.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(15) == 0) trip_low[b]  = ~trip_low[b];
                if ($urandom_range(15) == 0) trip_high[b] = ~trip_high[b];
            end
            bus.ready     = ($urandom_range(3) != 0);
            enable        = ($urandom_range(7) != 0);
            clear_request = ($urandom_range(31) == 0);
            step("rnd");
        end
        clear_request = 1'b0;
        enable = 1'b1;

        // Reset during a stalled beat.
        bus.ready = 1'b1;
        for (int i = 0; i < 12; i++) step("t6.drain");
        bus.ready = 1'b0;
        trip_low[0] = ~trip_low[0];
        step("t6.edge");
        step("t6.load");
        chk("t6.pre_valid", 64'(bus.valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6.async_drop", 64'(bus.valid), 64'd0);
        chk("t6.ovf_rst", 64'(overflow), 64'd0);
        trip_high = '0; trip_low = '0;
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("t6.after");
            chk("t6.no_stale", 64'(bus.valid), 64'd0);
        end
        chk("t6.ovf", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
